alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-003 issue_valid  input  1  operation offered by the ALU reservation station (its rs_ready).
REQ-004 issue_opcode  input  3  operation code.
REQ-005 issue_val1  input  3  operand 1.
REQ-006 issue_val2  input  3  operand 2.
REQ-007 issue_rob_idx  input  2  ROB tag of the offered operation.
REQ-008 flush  input  1  synchronous squash of any in-flight operation.
REQ-009 cdb_grant  input  1  CDB arbiter grant for this unit, valid in the same cycle as cdb_req.
REQ-010 alu_busy  output  1  unit cannot accept an issue this cycle; fed back to the reservation station.
REQ-011 cdb_req  output  1  result held and waiting for the CDB.
REQ-012 cdb_en  output  1  result broadcast on the CDB this cycle.
REQ-013 cdb_rob_idx  output  2  tag of the broadcast result.
REQ-014 cdb_val  output  3  broadcast result value.

Function
REQ-015 The FSM SHALL have the states IDLE, EXEC and WAIT_CDB.
REQ-016 alu_busy SHALL be 1 in every state except IDLE; it is a registered-state decode only, with no combinational path from any input.
REQ-017 IDLE with issue_valid=1 and flush=0 SHALL, at the clock edge:
- latch opcode, val1, val2 and rob_idx;
- load the latency counter with 2 for MUL and 0 otherwise;
- move to EXEC.
REQ-018 In IDLE, issue_valid SHALL be ignored whenever flush=1.
REQ-019 EXEC with counter>0 SHALL decrement the counter.
REQ-020 EXEC with counter=0 SHALL compute the result, register it, and move to WAIT_CDB.
REQ-021 Opcodes SHALL be:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
- 5 SLL and 6 SRL, shift amount val2[1:0], with 0 or 3 giving shifts of 0 or 3;
- 7 MUL.
REQ-022 All arithmetic results SHALL be truncated to the low 3 bits (modulo 8); SUB wraps.
REQ-023 cdb_req SHALL be 1 exactly when the state is WAIT_CDB.
REQ-024 cdb_en SHALL equal (state==WAIT_CDB) AND cdb_grant AND NOT flush.
REQ-025 cdb_rob_idx and cdb_val SHALL carry the latched tag and result whenever cdb_en=1, and SHALL be 0 whenever cdb_en=0.
REQ-026 WAIT_CDB with cdb_en=1 SHALL return to IDLE at the next edge.
REQ-027 WAIT_CDB without a grant SHALL hold the state and the result indefinitely.
REQ-028 Latency SHALL be counted from the cycle in which the issue is sampled (cycle 0), assuming the grant is present:
- non-MUL: cdb_en in cycle 2;
- MUL: cdb_en in cycle 4;
- the next issue is accepted no earlier than the cycle after the broadcast.
REQ-029 flush=1 in any state SHALL:
- return the FSM to IDLE at the next edge;
- discard the latched operation;
- suppress cdb_en in that same cycle.
REQ-030 cdb_grant outside WAIT_CDB SHALL have no effect.
REQ-031 Opcodes are fully decoded, so no illegal-opcode case exists.

Reset
REQ-032 rst_n=0 SHALL immediately force:
- state to IDLE;
- the counter and all latched fields to 0;
- alu_busy, cdb_req, cdb_en, cdb_rob_idx and cdb_val to 0.
REQ-033 Reset asserted mid-operation (in EXEC or WAIT_CDB) SHALL drop the operation, and no broadcast SHALL follow after reset is released.

Structure
REQ-034 A shared package SHALL hold:
- the opcode enum (ADD..MUL);
- the FSM state enum;
- the MUL_EXTRA_CYCLES=2 constant;
- the widths: VAL_W=3, TAG_W=2, OP_W=3.
REQ-035 The purely combinational opcode evaluator SHALL be a single sub-module, alu_core, instantiated once inside alu_exec_unit.

Verification
REQ-036 ADD, issue val1=3, val2=6, tag=2, grant held at 1 -> cdb_en=1 with cdb_val=1 and cdb_rob_idx=2 in cycle 2; alu_busy=1 in cycles 1-2.
REQ-037 MUL, val1=3, val2=3, tag=1, grant held at 1 -> cdb_en in cycle 4 with cdb_val=1; alu_busy=1 in cycles 1-4.
REQ-038 SUB, val1=1, val2=2, grant withheld until cycle 6 -> cdb_req=1 in cycles 2-6, cdb_en=1 only in cycle 6 with cdb_val=7, IDLE in cycle 7.
REQ-039 MUL issued, flush pulsed in cycle 2 -> no cdb_en ever; alu_busy=0 from cycle 3; a new issue is accepted in cycle 3.
REQ-040 rst_n low in WAIT_CDB with grant=1 -> all outputs 0 immediately; nothing is broadcast after release.
REQ-041 Back-to-back issues: XOR 5^3 (tag 0), then SLL 3<<2 (tag 3) offered from cycle 3 -> cdb_val=6 in cycle 2 and cdb_val=4 in cycle 5.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared types and widths for the ALU execution unit and its opcode evaluator.
package alu_exec_unit_pkg;

    localparam int VAL_W            = 3;
    localparam int TAG_W            = 2;
    localparam int OP_W             = 3;
    localparam int MUL_EXTRA_CYCLES = 2;
    localparam int CNT_W            = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_CDB = 2'd2
    } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue-side and CDB-side signals of the ALU execution unit.
interface alu_exec_unit_if;
    import alu_exec_unit_pkg::*;

    logic             issue_valid;
    logic [OP_W-1:0]  issue_opcode;
    logic [VAL_W-1:0] issue_val1;
    logic [VAL_W-1:0] issue_val2;
    logic [TAG_W-1:0] issue_rob_idx;
    logic             flush;
    logic             cdb_grant;
    logic             alu_busy;
    logic             cdb_req;
    logic             cdb_en;
    logic [TAG_W-1:0] cdb_rob_idx;
    logic [VAL_W-1:0] cdb_val;

    modport master (
        output issue_valid, issue_opcode, issue_val1, issue_val2, issue_rob_idx,
        output flush, cdb_grant,
        input  alu_busy, cdb_req, cdb_en, cdb_rob_idx, cdb_val
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_val1, issue_val2, issue_rob_idx,
        input  flush, cdb_grant,
        output alu_busy, cdb_req, cdb_en, cdb_rob_idx, cdb_val
    );

endinterface

// File: rtl/alu_exec_unit_core.sv
// Purely combinational opcode evaluator; every result wraps to VAL_W bits.
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  opcode_e          op,
    input  logic [VAL_W-1:0] a,
    input  logic [VAL_W-1:0] b,
    output logic [VAL_W-1:0] result
);

    // Shifts use only the low two bits of b as the shift amount.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << b[1:0];
            OP_SRL:  result = a >> b[1:0];
            OP_MUL:  result = a * b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-entry ALU execution unit: accepts one issue, waits its latency, holds the result until the CDB grants it.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_unit_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    opcode_e          op_q, op_d;
    logic [VAL_W-1:0] val1_q, val1_d;
    logic [VAL_W-1:0] val2_q, val2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [VAL_W-1:0] result_q, result_d;
    logic [VAL_W-1:0] core_result;

    alu_core u_core (
        .op     (op_q),
        .a      (val1_q),
        .b      (val2_q),
        .result (core_result)
    );

    // Busy and request are pure state decodes so the reservation station sees no input-to-output path.
    assign bus.alu_busy    = (state_q != IDLE);
    assign bus.cdb_req     = (state_q == WAIT_CDB);
    assign bus.cdb_en      = bus.cdb_req && bus.cdb_grant && !bus.flush;
    assign bus.cdb_rob_idx = bus.cdb_en ? tag_q : '0;
    assign bus.cdb_val     = bus.cdb_en ? result_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            val1_q   <= '0;
            val2_q   <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            val1_q   <= val1_d;
            val2_q   <= val2_d;
            tag_q    <= tag_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        val1_d   = val1_q;
        val2_d   = val2_q;
        tag_d    = tag_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (bus.issue_valid) begin
                    op_d    = opcode_e'(bus.issue_opcode);
                    val1_d  = bus.issue_val1;
                    val2_d  = bus.issue_val2;
                    tag_d   = bus.issue_rob_idx;
                    cnt_d   = (opcode_e'(bus.issue_opcode) == OP_MUL) ? CNT_W'(MUL_EXTRA_CYCLES) : '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    result_d = core_result;
                    state_d  = WAIT_CDB;
                end
            end
            WAIT_CDB: begin
                if (bus.cdb_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything, including a same-cycle issue in IDLE.
        if (bus.flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            op_d     = OP_ADD;
            val1_d   = '0;
            val2_d   = '0;
            tag_d    = '0;
            result_d = '0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized traffic against a timeline model.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] obs;

    alu_exec_unit_if bus();

    alu_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {busy, req, en, rob_idx[1:0], val[2:0]}.
    assign obs = {bus.alu_busy, bus.cdb_req, bus.cdb_en, bus.cdb_rob_idx, bus.cdb_val};

    task automatic drive(input bit iv, input int op, input int v1, input int v2,
                         input int tag, input bit gr, input bit fl);
        bus.issue_valid   = iv;
        bus.issue_opcode  = 3'(op);
        bus.issue_val1    = 3'(v1);
        bus.issue_val2    = 3'(v2);
        bus.issue_rob_idx = 2'(tag);
        bus.cdb_grant     = gr;
        bus.flush         = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_result(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b + 8;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * (2 ** (b % 4));
            6: r = a / (2 ** (b % 4));
            default: r = a * b;
        endcase
        return r % 8;
    endfunction

    function automatic logic [7:0] pack(input bit busy, input bit req, input bit en,
                                        input int tag, input int val);
        return {busy, req, en, 2'(tag), 3'(val)};
    endfunction

    task automatic test_reset();
        logic [7:0] exp;
        exp = 8'h00;
        drive(1, 7, 3, 3, 1, 1, 0);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: got %b expected %b", obs, exp);
        end
        step();
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: got %b expected %b", obs, exp);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got %b expected %b", obs, exp);
        end
        step();
    endtask

    task automatic test_add();
        logic [7:0] exp;
        drive(1, 0, 3, 6, 2, 1, 0);
        for (int c = 0; c <= 3; c++) begin
            if (c == 1) drive(0, 0, 0, 0, 0, 1, 0);
            #1;
            case (c)
                1:       exp = pack(1, 0, 0, 0, 0);
                2:       exp = pack(1, 1, 1, 2, 1);
                default: exp = pack(0, 0, 0, 0, 0);
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL add_c%0d: got %b expected %b", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_mul();
        logic [7:0] exp;
        drive(1, 7, 3, 3, 1, 1, 0);
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) drive(0, 0, 0, 0, 0, 1, 0);
            #1;
            if (c == 0 || c == 5)  exp = pack(0, 0, 0, 0, 0);
            else if (c == 4)       exp = pack(1, 1, 1, 1, 1);
            else                   exp = pack(1, 0, 0, 0, 0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL mul_c%0d: got %b expected %b", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_sub_wait();
        logic [7:0] exp;
        drive(1, 1, 1, 2, 3, 0, 0);
        for (int c = 0; c <= 7; c++) begin
            if (c == 1) drive(0, 0, 0, 0, 0, 0, 0);
            if (c == 6) bus.cdb_grant = 1'b1;
            #1;
            if (c == 0 || c == 7)  exp = pack(0, 0, 0, 0, 0);
            else if (c == 1)       exp = pack(1, 0, 0, 0, 0);
            else if (c == 6)       exp = pack(1, 1, 1, 3, 7);
            else                   exp = pack(1, 1, 0, 0, 0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL sub_wait_c%0d: got %b expected %b", c, obs, exp);
            end
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        logic [7:0] exp;
        drive(1, 7, 2, 3, 1, 1, 0);
        for (int c = 0; c <= 6; c++) begin
            if (c == 1) drive(0, 0, 0, 0, 0, 1, 0);
            if (c == 2) bus.flush = 1'b1;
            if (c == 3) drive(1, 0, 1, 1, 0, 1, 0);
            if (c == 4) drive(0, 0, 0, 0, 0, 1, 0);
            #1;
            case (c)
                1, 2, 4: exp = pack(1, 0, 0, 0, 0);
                5:       exp = pack(1, 1, 1, 0, 2);
                default: exp = pack(0, 0, 0, 0, 0);
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL flush_c%0d: got %b expected %b", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        drive(1, 3, 5, 2, 3, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        #1;
        exp = pack(1, 1, 0, 0, 0);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_wait: got %b expected %b", obs, exp);
        end
        bus.cdb_grant = 1'b1;
        rst_n = 1'b0;
        #1;
        exp = 8'h00;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_assert: got %b expected %b", obs, exp);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL rstmid_after_c%0d: got %b expected %b", c, obs, exp);
            end
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        drive(1, 4, 5, 3, 0, 1, 0);
        for (int c = 0; c <= 6; c++) begin
            if (c == 1) drive(1, 5, 3, 2, 3, 1, 0);
            if (c == 4) drive(0, 0, 0, 0, 0, 1, 0);
            #1;
            case (c)
                1, 4:    exp = pack(1, 0, 0, 0, 0);
                2:       exp = pack(1, 1, 1, 0, 6);
                5:       exp = pack(1, 1, 1, 3, 4);
                default: exp = pack(0, 0, 0, 0, 0);
            endcase
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL b2b_c%0d: got %b expected %b", c, obs, exp);
            end
            step();
        end
    endtask

    // The model tracks only "an operation is pending, its result is ready from cycle done_at".
    task automatic test_random();
        logic [7:0] exp;
        bit pending = 0;
        int done_at = 0;
        int e_tag = 0;
        int e_val = 0;
        bit iv, gr, fl, e_req, e_en;
        int op, v1, v2, tag;
        for (int t = 0; t < 400; t++) begin
            iv  = ($urandom_range(0, 9) < 6);
            op  = $urandom_range(0, 7);
            v1  = $urandom_range(0, 7);
            v2  = $urandom_range(0, 7);
            tag = $urandom_range(0, 3);
            gr  = $urandom_range(0, 1);
            fl  = ($urandom_range(0, 19) == 0);
            drive(iv, op, v1, v2, tag, gr, fl);
            e_req = pending && (t >= done_at);
            e_en  = e_req && gr && !fl;
            exp   = pack(pending, e_req, e_en, e_en ? e_tag : 0, e_en ? e_val : 0);
            #1;
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL random_t%0d: got %b expected %b", t, obs, exp);
            end
            if (fl || e_en) begin
                pending = 0;
            end else if (!pending && iv) begin
                pending = 1;
                done_at = t + ((op == 7) ? 4 : 2);
                e_tag   = tag;
                e_val   = exp_result(op, v1, v2);
            end
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_sub_wait();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
